nonogram_line_engine: RTL and testbench
=======================================

Name: nonogram_line_engine

Overview:
- Parametrised line-solving core for the nonogram solver. It handles one row or column at a time.
- It receives a line command, then streams that line's candidate options. Each option is checked against the current grid and tagged keep or drop, so the caller knows whether to re-queue it.
- At end of line it folds the bits common to all surviving options into the known/assigned grid, and reports the new option count and progress.
- It sits between the option FIFO/BRAM controller and the board state, and replaces the fixed 3x3 solver.

Parameters:
- SIZE, 5, board edge length. Line indices 0..SIZE-1 are rows; SIZE..2*SIZE-1 are columns.
- CNT_W, 10, width of option counts.
- IDX_W, $clog2(2*SIZE), width of the line index.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- grid_clear  in  1  synchronous clear of the grid and abort to IDLE.
- line_valid  in  1  line command valid.
- line_ready  out  1  engine can accept a line command.
- line_idx  in  IDX_W  row (<SIZE) or column (>=SIZE) index.
- line_opt_cnt  in  CNT_W  number of options that will follow for this line.
- opt_valid  in  1  option valid.
- opt_ready  out  1  option accepted when high with opt_valid.
- opt_data  in  SIZE  candidate line. Bit k is cell k along the line: column k for a row, row k for a column.
- keep_valid  out  1  one-cycle pulse per accepted option.
- keep  out  1  1 = option consistent, re-queue it; 0 = contradicts, drop it.
- line_done  out  1  one-cycle pulse at end of line.
- new_opt_cnt  out  CNT_W  surviving options for the finished line.
- progress  out  1  with line_done: at least one cell became newly known.
- contradiction  out  1  with line_done: zero options survived.
- known  out  SIZE*SIZE  per-cell known flag; cell (r,c) is bit r*SIZE+c.
- assigned  out  SIZE*SIZE  per-cell value, meaningful only where known=1.
- solved  out  1  registered AND of all known bits.

Behaviour:
- Reset: state IDLE; known=0, assigned=0. line_ready=1 in IDLE. opt_ready=0, keep_valid=0, keep=0, line_done=0, new_opt_cnt=0, progress=0, contradiction=0, solved=0.
- grid_clear: same effect as rst, in any state; any in-flight line is discarded with no line_done. rst wins if both are asserted.
- State IDLE (line_ready=1):
  - On line_valid, latch line_idx and remaining=line_opt_cnt.
  - Clear survivors=0, and_acc=all ones, or_acc=0.
  - Go to SCAN if line_opt_cnt>0, else go to COMMIT.
  - line_idx >= 2*SIZE is out of range: the command is accepted and treated as zero options (contradiction).
- State SCAN (opt_ready=1):
  - Line extraction is combinational. Row r takes known/assigned bits r*SIZE..r*SIZE+SIZE-1. Column c takes bits k*SIZE+c for k=0..SIZE-1.
  - Per accepted option: conflict = |((opt_data ^ line_assigned) & line_known).
  - On conflict: drop the option.
  - Otherwise: survivors++, and_acc&=opt_data, or_acc|=opt_data.
  - keep_valid/keep are registered: option accepted at edge t gives the keep_valid pulse in cycle t+1.
  - remaining decrements per accept. Accepting the last option moves the engine to COMMIT.
  - The grid is not modified during SCAN; every option is checked against the pre-line grid.
- State COMMIT (one cycle, opt_ready=0):
  - If survivors>0, for each line bit k:
    - and_acc[k]=1 sets known=1, assigned=1;
    - or_acc[k]=0 sets known=1, assigned=0;
    - otherwise the cell is unchanged.
  - If survivors=0, no grid write.
  - progress = any cell written that was previously unknown.
  - At the end of COMMIT: grid updated, line_done pulses with new_opt_cnt=survivors, contradiction=(survivors==0). State returns to IDLE.
- Timing: the last option accepted at edge t gives a COMMIT cycle at t+1. line_done, the updated grid and line_ready=1 are visible from t+2.
- solved updates one cycle after known changes.
- Already-known cells are rewritten with the same value; a surviving option cannot disagree with them.
- survivors saturates at 2^CNT_W-1.

Test Plan:
- SIZE=3, row 0, 2 options: 3'b011, 3'b110, grid empty -> keep=1 twice; line_done, new_opt_cnt=2; known[2:0]=3'b010, assigned[1]=1; progress=1.
- After that row, column 1 (idx 4), options 3'b000 and 3'b001 -> 000 dropped (cell (0,1)=1 known), 001 kept; new_opt_cnt=1; column 1 fully known, values 1,0,0.
- Row 2, single option 3'b101, which conflicts with known cell (2,1)=0? No conflict -> keep=1; row fully known, progress=1. Repeat the same line -> progress=0.
- Row 1, options all conflicting -> keep=0 each; contradiction=1, new_opt_cnt=0, grid unchanged. Also line_opt_cnt=0 -> line_done at +2 cycles, contradiction=1.
- Backpressure: opt_valid toggled every other cycle -> only handshaken options counted; keep pulses align one cycle after each accept.
- grid_clear asserted mid-SCAN -> no line_done, known=0, line_ready=1 next cycle. Fill all cells -> solved=1.

Source files
------------

// File: rtl/nonogram_line_engine_if.sv
// rtl/nonogram_line_engine_if.sv - line command, option stream, result and grid signals of the line engine
interface nonogram_line_engine_if #(
  parameter int SIZE  = 5,
  parameter int CNT_W = 10,
  parameter int IDX_W = $clog2(2*SIZE)
);
  logic                   grid_clear;
  logic                   line_valid;
  logic                   line_ready;
  logic [IDX_W-1:0]       line_idx;
  logic [CNT_W-1:0]       line_opt_cnt;
  logic                   opt_valid;
  logic                   opt_ready;
  logic [SIZE-1:0]        opt_data;
  logic                   keep_valid;
  logic                   keep;
  logic                   line_done;
  logic [CNT_W-1:0]       new_opt_cnt;
  logic                   progress;
  logic                   contradiction;
  logic [SIZE*SIZE-1:0]   known;
  logic [SIZE*SIZE-1:0]   assigned;
  logic                   solved;

  modport master (
    output grid_clear, line_valid, line_idx, line_opt_cnt, opt_valid, opt_data,
    input  line_ready, opt_ready, keep_valid, keep, line_done, new_opt_cnt,
           progress, contradiction, known, assigned, solved
  );

  modport slave (
    input  grid_clear, line_valid, line_idx, line_opt_cnt, opt_valid, opt_data,
    output line_ready, opt_ready, keep_valid, keep, line_done, new_opt_cnt,
           progress, contradiction, known, assigned, solved
  );
endinterface

// File: rtl/nonogram_line_engine.sv
// rtl/nonogram_line_engine.sv - single-line nonogram solver: filters candidate options and folds common bits into the grid
module nonogram_line_engine #(
  parameter int SIZE  = 5,
  parameter int CNT_W = 10,
  parameter int IDX_W = $clog2(2*SIZE)
) (
  input  logic                  clk,
  input  logic                  rst,
  nonogram_line_engine_if.slave bus
);

  typedef enum logic [1:0] {S_IDLE, S_SCAN, S_COMMIT} state_t;

  state_t                 state_q, state_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic [CNT_W-1:0]       remaining_q, remaining_d;
  logic [CNT_W-1:0]       survivors_q, survivors_d;
  logic [SIZE-1:0]        and_acc_q, and_acc_d;
  logic [SIZE-1:0]        or_acc_q, or_acc_d;
  logic [SIZE*SIZE-1:0]   known_q, known_d;
  logic [SIZE*SIZE-1:0]   assigned_q, assigned_d;
  logic                   keep_valid_q, keep_valid_d;
  logic                   keep_q, keep_d;
  logic                   line_done_q, line_done_d;
  logic [CNT_W-1:0]       new_opt_cnt_q, new_opt_cnt_d;
  logic                   progress_q, progress_d;
  logic                   contradiction_q, contradiction_d;
  logic                   solved_q, solved_d;

  logic                   is_col;
  int                     sel;
  logic [SIZE-1:0]        line_known;
  logic [SIZE-1:0]        line_assigned;
  logic                   conflict;
  logic                   wrote_new;

  // Flat grid bit for cell k along the selected line.
  function automatic int cell_of(input logic col, input int s, input int k);
    cell_of = col ? (k * SIZE + s) : (s * SIZE + k);
  endfunction

  always_comb begin
    is_col        = int'(idx_q) >= SIZE;
    sel           = is_col ? int'(idx_q) - SIZE : int'(idx_q);
    line_known    = '0;
    line_assigned = '0;
    if (sel < SIZE) begin
      for (int k = 0; k < SIZE; k++) begin
        line_known[k]    = known_q[cell_of(is_col, sel, k)];
        line_assigned[k] = assigned_q[cell_of(is_col, sel, k)];
      end
    end
  end

  always_comb begin
    state_d         = state_q;
    idx_d           = idx_q;
    remaining_d     = remaining_q;
    survivors_d     = survivors_q;
    and_acc_d       = and_acc_q;
    or_acc_d        = or_acc_q;
    known_d         = known_q;
    assigned_d      = assigned_q;
    keep_valid_d    = 1'b0;
    keep_d          = 1'b0;
    line_done_d     = 1'b0;
    new_opt_cnt_d   = new_opt_cnt_q;
    progress_d      = progress_q;
    contradiction_d = contradiction_q;
    solved_d        = &known_q;
    wrote_new       = 1'b0;
    conflict        = |((bus.opt_data ^ line_assigned) & line_known);

    case (state_q)
      S_IDLE: begin
        if (bus.line_valid) begin
          idx_d       = bus.line_idx;
          remaining_d = bus.line_opt_cnt;
          survivors_d = '0;
          and_acc_d   = '1;
          or_acc_d    = '0;
          // An out-of-range index behaves as an empty line and reports a contradiction.
          if (int'(bus.line_idx) >= 2 * SIZE || bus.line_opt_cnt == '0) begin
            state_d = S_COMMIT;
          end else begin
            state_d = S_SCAN;
          end
        end
      end

      S_SCAN: begin
        if (bus.opt_valid) begin
          keep_valid_d = 1'b1;
          keep_d       = !conflict;
          if (!conflict) begin
            if (survivors_q != '1) begin
              survivors_d = survivors_q + 1'b1;
            end
            and_acc_d = and_acc_q & bus.opt_data;
            or_acc_d  = or_acc_q | bus.opt_data;
          end
          remaining_d = remaining_q - 1'b1;
          if (remaining_q == CNT_W'(1)) begin
            state_d = S_COMMIT;
          end
        end
      end

      S_COMMIT: begin
        if (survivors_q != '0) begin
          for (int k = 0; k < SIZE; k++) begin
            if (and_acc_q[k] || !or_acc_q[k]) begin
              if (!known_q[cell_of(is_col, sel, k)]) begin
                wrote_new = 1'b1;
              end
              known_d[cell_of(is_col, sel, k)]    = 1'b1;
              assigned_d[cell_of(is_col, sel, k)] = and_acc_q[k];
            end
          end
        end
        line_done_d     = 1'b1;
        new_opt_cnt_d   = survivors_q;
        contradiction_d = (survivors_q == '0);
        progress_d      = wrote_new;
        state_d         = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst || bus.grid_clear) begin
      state_q         <= S_IDLE;
      idx_q           <= '0;
      remaining_q     <= '0;
      survivors_q     <= '0;
      and_acc_q       <= '1;
      or_acc_q        <= '0;
      known_q         <= '0;
      assigned_q      <= '0;
      keep_valid_q    <= 1'b0;
      keep_q          <= 1'b0;
      line_done_q     <= 1'b0;
      new_opt_cnt_q   <= '0;
      progress_q      <= 1'b0;
      contradiction_q <= 1'b0;
      solved_q        <= 1'b0;
    end else begin
      state_q         <= state_d;
      idx_q           <= idx_d;
      remaining_q     <= remaining_d;
      survivors_q     <= survivors_d;
      and_acc_q       <= and_acc_d;
      or_acc_q        <= or_acc_d;
      known_q         <= known_d;
      assigned_q      <= assigned_d;
      keep_valid_q    <= keep_valid_d;
      keep_q          <= keep_d;
      line_done_q     <= line_done_d;
      new_opt_cnt_q   <= new_opt_cnt_d;
      progress_q      <= progress_d;
      contradiction_q <= contradiction_d;
      solved_q        <= solved_d;
    end
  end

  assign bus.line_ready    = (state_q == S_IDLE);
  assign bus.opt_ready     = (state_q == S_SCAN);
  assign bus.keep_valid    = keep_valid_q;
  assign bus.keep          = keep_q;
  assign bus.line_done     = line_done_q;
  assign bus.new_opt_cnt   = new_opt_cnt_q;
  assign bus.progress      = progress_q;
  assign bus.contradiction = contradiction_q;
  assign bus.known         = known_q;
  assign bus.assigned      = assigned_q;
  assign bus.solved        = solved_q;

endmodule

// File: tb/tb_nonogram_line_engine.sv
// tb/tb_nonogram_line_engine.sv - directed and randomized line sequences checked against a cell-array model
module tb_nonogram_line_engine;
  localparam int S  = 3;
  localparam int CW = 10;
  localparam int IW = 3;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  nonogram_line_engine_if #(.SIZE(S), .CNT_W(CW), .IDX_W(IW)) bus ();
  nonogram_line_engine #(.SIZE(S), .CNT_W(CW), .IDX_W(IW)) dut (.clk(clk), .rst(rst), .bus(bus));

  int n_cmp = 0;
  int n_err = 0;
  bit m_known [S][S];
  bit m_val   [S][S];
  logic [S-1:0] opt_q [$];

  function automatic logic [S*S-1:0] pack_known();
    logic [S*S-1:0] v;
    for (int r = 0; r < S; r++) for (int c = 0; c < S; c++) v[r*S+c] = m_known[r][c];
    return v;
  endfunction

  function automatic logic [S*S-1:0] pack_val();
    logic [S*S-1:0] v;
    for (int r = 0; r < S; r++) for (int c = 0; c < S; c++) v[r*S+c] = m_val[r][c];
    return v;
  endfunction

  task automatic model_clear();
    for (int r = 0; r < S; r++) for (int c = 0; c < S; c++) begin
      m_known[r][c] = 1'b0;
      m_val[r][c]   = 1'b0;
    end
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // gap_mode: 0 = streaming, 1 = idle cycle before every option, 2 = random idle cycles
  task automatic run_line(input int idx, input int cnt, input int gap_mode, input string tag);
    logic [S-1:0] lk, la;
    logic [S-1:0] surv [$];
    bit cf, all1, all0, exp_prog;
    int r, c, n_opt;
    surv.delete();
    n_opt = (idx < 2*S) ? cnt : 0;
    lk = '0;
    la = '0;
    for (int k = 0; k < S && idx < 2*S; k++) begin
      r = (idx < S) ? idx : k;
      c = (idx < S) ? k : idx - S;
      lk[k] = m_known[r][c];
      la[k] = m_val[r][c];
    end
    chk({tag, "/line_ready"}, bus.line_ready, 1);
    bus.line_valid   = 1'b1;
    bus.line_idx     = IW'(idx);
    bus.line_opt_cnt = CW'(cnt);
    @(posedge clk); #1;
    bus.line_valid = 1'b0;
    for (int i = 0; i < n_opt; i++) begin
      if (gap_mode == 1 || (gap_mode == 2 && $urandom_range(0, 1) == 1)) begin
        bus.opt_valid = 1'b0;
        @(posedge clk); #1;
        chk({tag, "/keep_valid_gap"}, bus.keep_valid, 0);
      end
      chk({tag, "/opt_ready"}, bus.opt_ready, 1);
      bus.opt_valid = 1'b1;
      bus.opt_data  = opt_q[i];
      @(posedge clk); #1;
      bus.opt_valid = 1'b0;
      cf = 1'b0;
      for (int k = 0; k < S; k++) if (lk[k] && (opt_q[i][k] != la[k])) cf = 1'b1;
      if (!cf) surv.push_back(opt_q[i]);
      chk({tag, "/keep_valid"}, bus.keep_valid, 1);
      chk({tag, "/keep"}, bus.keep, !cf);
    end
    chk({tag, "/opt_ready_commit"}, bus.opt_ready, 0);
    chk({tag, "/line_done_early"}, bus.line_done, 0);
    @(posedge clk); #1;
    exp_prog = 1'b0;
    if (surv.size() > 0) begin
      for (int k = 0; k < S; k++) begin
        all1 = 1'b1;
        all0 = 1'b1;
        foreach (surv[j]) if (surv[j][k]) all0 = 1'b0; else all1 = 1'b0;
        if (all1 || all0) begin
          r = (idx < S) ? idx : k;
          c = (idx < S) ? k : idx - S;
          if (!m_known[r][c]) exp_prog = 1'b1;
          m_known[r][c] = 1'b1;
          m_val[r][c]   = all1;
        end
      end
    end
    chk({tag, "/line_done"}, bus.line_done, 1);
    chk({tag, "/keep_valid_done"}, bus.keep_valid, 0);
    chk({tag, "/new_opt_cnt"}, bus.new_opt_cnt, surv.size());
    chk({tag, "/contradiction"}, bus.contradiction, surv.size() == 0);
    chk({tag, "/progress"}, bus.progress, exp_prog);
    chk({tag, "/known"}, bus.known, pack_known());
    chk({tag, "/assigned"}, bus.assigned, pack_val());
    chk({tag, "/line_ready_after"}, bus.line_ready, 1);
    @(posedge clk); #1;
    chk({tag, "/line_done_pulse"}, bus.line_done, 0);
    chk({tag, "/solved"}, bus.solved, &pack_known());
  endtask

  task automatic do_clear(input string tag);
    bus.grid_clear = 1'b1;
    @(posedge clk); #1;
    bus.grid_clear = 1'b0;
    model_clear();
    chk({tag, "/known"}, bus.known, 0);
    chk({tag, "/assigned"}, bus.assigned, 0);
    chk({tag, "/line_ready"}, bus.line_ready, 1);
    chk({tag, "/solved"}, bus.solved, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    bus.grid_clear   = 1'b0;
    bus.line_valid   = 1'b0;
    bus.line_idx     = '0;
    bus.line_opt_cnt = '0;
    bus.opt_valid    = 1'b0;
    bus.opt_data     = '0;
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("reset/line_ready", bus.line_ready, 1);
    chk("reset/opt_ready", bus.opt_ready, 0);
    chk("reset/keep_valid", bus.keep_valid, 0);
    chk("reset/keep", bus.keep, 0);
    chk("reset/line_done", bus.line_done, 0);
    chk("reset/new_opt_cnt", bus.new_opt_cnt, 0);
    chk("reset/progress", bus.progress, 0);
    chk("reset/contradiction", bus.contradiction, 0);
    chk("reset/known", bus.known, 0);
    chk("reset/assigned", bus.assigned, 0);
    chk("reset/solved", bus.solved, 0);

    opt_q = '{3'b011, 3'b110};
    run_line(0, 2, 0, "row0");
    chk("row0/known_lit", bus.known, 9'b000_000_010);
    chk("row0/assigned_lit", bus.assigned, 9'b000_000_010);

    opt_q = '{3'b000, 3'b001};
    run_line(4, 2, 0, "col1");
    chk("col1/known_lit", bus.known, 9'b010_010_010);
    chk("col1/assigned_lit", bus.assigned, 9'b000_000_010);

    opt_q = '{3'b101};
    run_line(2, 1, 0, "row2");
    chk("row2/known_lit", bus.known, 9'b111_010_010);
    chk("row2/assigned_lit", bus.assigned, 9'b101_000_010);
    run_line(2, 1, 0, "row2_again");
    chk("row2_again/progress_lit", bus.progress, 0);

    opt_q = '{3'b010, 3'b111};
    run_line(1, 2, 0, "row1_conflict");
    chk("row1_conflict/known_lit", bus.known, 9'b111_010_010);

    opt_q.delete();
    run_line(1, 0, 0, "zero_cnt");
    run_line(6, 3, 0, "oob6");
    run_line(7, 1, 0, "oob7");

    opt_q.delete();
    for (int i = 0; i < 4; i++) opt_q.push_back(S'($urandom_range(0, 7)));
    run_line(5, 4, 1, "backpressure");

    opt_q = '{3'b001, 3'b010, 3'b100};
    bus.line_valid   = 1'b1;
    bus.line_idx     = IW'(3);
    bus.line_opt_cnt = CW'(3);
    @(posedge clk); #1;
    bus.line_valid = 1'b0;
    bus.opt_valid  = 1'b1;
    bus.opt_data   = opt_q[0];
    @(posedge clk); #1;
    bus.opt_valid  = 1'b0;
    bus.grid_clear = 1'b1;
    @(posedge clk); #1;
    bus.grid_clear = 1'b0;
    model_clear();
    chk("midclear/line_ready", bus.line_ready, 1);
    chk("midclear/known", bus.known, 0);
    chk("midclear/opt_ready", bus.opt_ready, 0);
    for (int i = 0; i < 3; i++) begin
      chk("midclear/no_line_done", bus.line_done, 0);
      @(posedge clk); #1;
    end

    for (int r = 0; r < S; r++) begin
      opt_q = '{S'($urandom_range(0, 7))};
      run_line(r, 1, 0, "fill");
    end
    chk("fill/solved_lit", bus.solved, 1);

    do_clear("clear");
    for (int n = 0; n < 40; n++) begin
      int idx, cnt;
      if (n == 20) do_clear("clear_mid");
      idx = $urandom_range(0, 6);
      cnt = $urandom_range(0, 5);
      opt_q.delete();
      for (int i = 0; i < cnt; i++) opt_q.push_back(S'($urandom_range(0, 7)));
      run_line(idx, cnt, 2, "rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
